// File: rtl/apb_regbank_pkg.sv
// Shared definitions for the APB register bank slave.
//   state_t         : access FSM states (IDLE / ACCESS)
//   MAX_WAIT_STATES : largest wait-state count the 4-bit counter can hold
//   err_cause_t     : reason a transfer completes with pslverr
package apb_regbank_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  localparam int unsigned MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_RO    = 2'd3
  } err_cause_t;

endpackage

// File: rtl/apb_access_fsm.sv
// APB access sequencer: tracks setup/access phases and inserts wait states.
// Ports:
//   clk, preset     : clock, synchronous active-high reset
//   psel, penable   : APB control inputs
//   pready          : high for exactly the completing cycle of an access
module apb_access_fsm
  import apb_regbank_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > MAX_WAIT_STATES) ?
                                     4'(MAX_WAIT_STATES) : 4'(WAIT_STATES);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (preset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pready  = 1'b0;
    case (state)
      ST_IDLE: begin
        // penable without a preceding setup phase is ignored here
        if (psel && !penable) begin
          state_n = ST_ACCESS;
          cnt_n   = WAIT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (!penable) begin
          // a repeated setup phase restarts the wait sequence
          cnt_n = WAIT_LOAD;
        end else if (cnt != '0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          // reset in the completing cycle suppresses the handshake
          pready  = !preset;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave exposing NUM_REGS word registers with byte strobes, optional
// wait states, and hardware-owned read-only registers.
// Ports:
//   clk, preset                         : clock, synchronous active-high reset
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb                       : APB request
//   pready, pslverr, prdata             : APB response
//   regs_o                              : flattened RW register contents
//   hw_status_i                         : read data for RO registers
//   wr_pulse_o, rd_pulse_o              : per-register successful access strobes
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          ADDR_W      = 12,
  parameter int unsigned          NUM_REGS    = 10,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic                         pready,
  output logic                         pslverr,
  output logic [DATA_W-1:0]            prdata,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o,
  output logic [NUM_REGS-1:0]          rd_pulse_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFS   = $clog2(NB);
  localparam int unsigned IDX_W = ADDR_W - OFS;

  logic                access_ready;
  logic [IDX_W-1:0]    idx;
  logic [NUM_REGS-1:0] sel;
  logic                in_range;
  logic                misalign;
  logic                ro_hit;
  err_cause_t          err_cause;
  logic                do_wr;
  logic                do_rd;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  apb_access_fsm #(
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .clk     (clk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pready  (access_ready)
  );

  assign idx      = paddr[ADDR_W-1:OFS];
  assign misalign = |paddr[OFS-1:0];

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
  end

  assign in_range = |sel;
  assign ro_hit   = |(sel & RO_MASK);

  always_comb begin
    err_cause = ERR_NONE;
    if (!in_range)             err_cause = ERR_RANGE;
    else if (misalign)         err_cause = ERR_ALIGN;
    else if (pwrite && ro_hit) err_cause = ERR_RO;
  end

  assign pready     = access_ready;
  assign pslverr    = access_ready && (err_cause != ERR_NONE);
  assign do_wr      = access_ready && (err_cause == ERR_NONE) && pwrite;
  assign do_rd      = access_ready && (err_cause == ERR_NONE) && !pwrite;
  assign wr_pulse_o = do_wr ? sel : '0;
  assign rd_pulse_o = do_rd ? sel : '0;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) begin
        rd_val = RO_MASK[i] ? hw_status_i[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  assign prdata = do_rd ? rd_val : '0;

  // RO registers are tied to zero so no storage survives for them
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (preset || RO_MASK[i]) begin
        regs_q[i] <= '0;
      end else if (wr_pulse_o[i]) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (pstrb[k]) regs_q[i][k*8 +: 8] <= pwdata[k*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed self-checking bench for apb_regbank_slave.
// Three instances: A = defaults, B = 3 wait states with register 4 read-only,
// C = 5 wait states for the mid-access reset case.
module tb_apb_regbank_slave;

  logic                 clk;
  logic [2:0]           preset;
  logic [2:0]           psel;
  logic                 penable;
  logic                 pwrite;
  logic [11:0]          paddr;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic [319:0]         hw_status;
  logic [2:0]           pready;
  logic [2:0]           pslverr;
  logic [2:0][31:0]     prdata;
  logic [2:0][319:0]    regs;
  logic [2:0][9:0]      wrp;
  logic [2:0][9:0]      rdp;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_regbank_slave #(.WAIT_STATES(0)) u_a (
    .clk(clk), .preset(preset[0]), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[0]), .pslverr(pslverr[0]), .prdata(prdata[0]),
    .regs_o(regs[0]), .hw_status_i(hw_status),
    .wr_pulse_o(wrp[0]), .rd_pulse_o(rdp[0])
  );

  apb_regbank_slave #(.WAIT_STATES(3), .RO_MASK(10'h010)) u_b (
    .clk(clk), .preset(preset[1]), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[1]), .pslverr(pslverr[1]), .prdata(prdata[1]),
    .regs_o(regs[1]), .hw_status_i(hw_status),
    .wr_pulse_o(wrp[1]), .rd_pulse_o(rdp[1])
  );

  apb_regbank_slave #(.WAIT_STATES(5)) u_c (
    .clk(clk), .preset(preset[2]), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[2]), .pslverr(pslverr[2]), .prdata(prdata[2]),
    .regs_o(regs[2]), .hw_status_i(hw_status),
    .wr_pulse_o(wrp[2]), .rd_pulse_o(rdp[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance d; returns after the completing edge.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output int waits, output logic [31:0] rd, output logic err,
                      output logic [9:0] wp, output logic [9:0] rp);
    bit done;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    chk("setup_pready", pready[d], 0);
    chk("setup_pulses", {wrp[d], rdp[d]}, 0);
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; done = 0; rd = '0; err = 1'b0; wp = '0; rp = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (pready[d]) begin
        rd = prdata[d]; err = pslverr[d]; wp = wrp[d]; rp = rdp[d]; done = 1;
      end else begin
        chk("wait_prdata", prdata[d], 0);
        chk("wait_pulses_err", {wrp[d], rdp[d], pslverr[d]}, 0);
        waits++;
      end
      @(posedge clk); #1;
    end
    chk("xfer_done", done, 1);
    psel = '0; penable = 1'b0;
  endtask

  int          w;
  logic [31:0] rd;
  logic        er;
  logic [9:0]  wp, rp;

  initial begin
    preset = 3'b111; psel = '0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0;
    hw_status = '0;
    hw_status[4*32 +: 32] = 32'h0000_0060;
    hw_status[0*32 +: 32] = 32'hBAD0_BAD0;  // RW slice: must be ignored

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", {prdata[0], prdata[1]}, 0);
    chk("rst_pulses", {wrp[0], rdp[0], wrp[1], rdp[1]}, 0);
    chk("rst_regs_a", |regs[0], 0);
    @(posedge clk); #1;
    preset = '0;

    // A: full-word write then read of register 1, no wait states
    xfer(0, 1, 12'h004, 32'hA5A5_1234, 4'hF, w, rd, er, wp, rp);
    chk("a_wr_waits", w, 0);
    chk("a_wr_err", er, 0);
    chk("a_wr_pulse", {wp, rp}, {10'h002, 10'h000});
    chk("a_reg1", regs[0][1*32 +: 32], 32'hA5A5_1234);
    xfer(0, 0, 12'h004, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("a_rd_waits", w, 0);
    chk("a_rd_data", rd, 32'hA5A5_1234);
    chk("a_rd_pulse", {wp, rp}, {10'h000, 10'h002});

    // A: byte strobes on register 2
    xfer(0, 1, 12'h008, 32'hFFFF_FFFF, 4'hF, w, rd, er, wp, rp);
    xfer(0, 1, 12'h008, 32'h0000_0000, 4'h5, w, rd, er, wp, rp);
    chk("a_strb_reg2", regs[0][2*32 +: 32], 32'hFF00_FF00);
    xfer(0, 0, 12'h008, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("a_strb_rd", rd, 32'hFF00_FF00);

    // A: pstrb=0 write keeps data but still pulses
    xfer(0, 1, 12'h008, 32'h1234_5678, 4'h0, w, rd, er, wp, rp);
    chk("a_nostrb_err", er, 0);
    chk("a_nostrb_pulse", wp, 10'h004);
    chk("a_nostrb_reg2", regs[0][2*32 +: 32], 32'hFF00_FF00);

    // A: out-of-range index and misaligned address
    xfer(0, 0, 12'h028, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("a_range_rd", {er, rd, wp, rp}, {1'b1, 32'h0, 20'h0});
    xfer(0, 1, 12'h028, 32'hFFFF_FFFF, 4'hF, w, rd, er, wp, rp);
    chk("a_range_wr", {er, wp, rp}, {1'b1, 20'h0});
    xfer(0, 1, 12'h006, 32'h0, 4'hF, w, rd, er, wp, rp);
    chk("a_align_wr", {er, wp, rp}, {1'b1, 20'h0});
    xfer(0, 0, 12'h006, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("a_align_rd", {er, rd, wp, rp}, {1'b1, 32'h0, 20'h0});
    chk("a_err_reg1", regs[0][1*32 +: 32], 32'hA5A5_1234);
    chk("a_err_reg2", regs[0][2*32 +: 32], 32'hFF00_FF00);
    chk("a_err_reg0", regs[0][0 +: 32], 32'h0);

    // A: psel dropped during access aborts the write
    psel = 3'b001; penable = 0; pwrite = 1; paddr = 12'h00C;
    pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = '0; penable = 1;
    @(negedge clk);
    chk("a_abort_pready", pready[0], 0);
    chk("a_abort_pulse", wrp[0], 0);
    // penable alone while idle is ignored
    @(posedge clk); #1;
    @(negedge clk);
    chk("a_idle_penable", pready[0], 0);
    @(posedge clk); #1;
    penable = 0;
    @(negedge clk);
    chk("a_abort_reg3", regs[0][3*32 +: 32], 32'h0);
    @(posedge clk); #1;

    // B: wait states, prdata only valid in the completing cycle
    xfer(1, 1, 12'h000, 32'hDEAD_BEEF, 4'hF, w, rd, er, wp, rp);
    chk("b_wr_waits", w, 3);
    chk("b_wr_pulse", wp, 10'h001);
    xfer(1, 0, 12'h000, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("b_rd_waits", w, 3);
    chk("b_rd_data", rd, 32'hDEAD_BEEF);
    chk("b_rd_pulse", rp, 10'h001);

    // B: read-only register 4
    xfer(1, 1, 12'h010, 32'h1111_1111, 4'hF, w, rd, er, wp, rp);
    chk("b_ro_wr_err", {er, wp}, {1'b1, 10'h0});
    xfer(1, 0, 12'h010, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("b_ro_rd", {er, rd, rp}, {1'b0, 32'h0000_0060, 10'h010});
    chk("b_ro_regs_o", regs[1][4*32 +: 32], 32'h0);

    // C: reset on the second wait cycle
    xfer(2, 1, 12'h004, 32'hCAFE_F00D, 4'hF, w, rd, er, wp, rp);
    chk("c_pre_reg1", regs[2][1*32 +: 32], 32'hCAFE_F00D);
    psel = 3'b100; penable = 0; pwrite = 1; paddr = 12'h000;
    pwdata = 32'h1111_2222; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("c_wait1_pready", pready[2], 0);
    @(posedge clk); #1;
    preset[2] = 1'b1;
    @(negedge clk);
    chk("c_rst_outputs", {pready[2], pslverr[2], prdata[2], wrp[2], rdp[2]}, 0);
    @(posedge clk); #1;
    preset[2] = 1'b0;
    @(negedge clk);
    chk("c_rst_no_commit", regs[2][0 +: 32], 32'h0);
    chk("c_rst_clears", regs[2][1*32 +: 32], 32'h0);
    // still selected with penable high after reset: no access without setup
    @(posedge clk); #1;
    @(negedge clk);
    chk("c_no_setup", pready[2], 0);
    @(posedge clk); #1;
    psel = '0; penable = 0;
    xfer(2, 1, 12'h000, 32'h1111_2222, 4'hF, w, rd, er, wp, rp);
    chk("c_post_wr", {w[7:0], er, wp}, {8'd5, 1'b0, 10'h001});
    xfer(2, 0, 12'h000, 32'h0, 4'h0, w, rd, er, wp, rp);
    chk("c_post_rd", {w[7:0], rd}, {8'd5, 32'h1111_2222});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_regbank_slave.md
APB_REGBANK_SLAVE -- requirements
Module: apb_regbank_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the APB data width (32 or 64 only).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the paddr width.
REQ-003 SHALL have parameter NUM_REGS, default 10, meaning the number of word registers (1..64).
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning the pready-low cycles inserted per access (0..15).
REQ-005 SHALL have parameter RO_MASK, default 0, a NUM_REGS-bit vector where bit i=1 makes register i hardware-owned and read-only.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port preset, input, 1, the reset: synchronous and active-high.
REQ-008 SHALL have ports psel, penable, pwrite: inputs, 1 bit each, APB control.
REQ-009 SHALL have ports paddr (ADDR_W), pwdata (DATA_W) and pstrb (DATA_W/8): inputs.
REQ-010 SHALL have ports pready and pslverr (outputs, 1 bit) and prdata (output, DATA_W).
REQ-011 SHALL have port regs_o, output, NUM_REGS*DATA_W: the flattened register contents, register i at slice i.
REQ-012 SHALL have port hw_status_i, input, NUM_REGS*DATA_W: read data for the RO registers; slices of RW registers are ignored.
REQ-013 SHALL have ports wr_pulse_o and rd_pulse_o, outputs, NUM_REGS each: one-cycle per-register strobes on a successful write/read.

Function
REQ-014 Byte offset bits SHALL be OFS=log2(DATA_W/8); register index = paddr[ADDR_W-1:OFS].
REQ-015 FSM SHALL have states IDLE and ACCESS plus a 4-bit wait counter.
REQ-016 IDLE->ACCESS when psel=1 and penable=0 (setup phase); counter loads WAIT_STATES.
REQ-017 In ACCESS with psel=1 and penable=1: counter>0 decrements with pready=0; counter==0 gives pready=1 for exactly that cycle and then IDLE.
REQ-018 psel=0 in ACCESS SHALL return to IDLE with no commit, no pulse and pready=0.
REQ-019 penable=1 observed in IDLE SHALL be ignored (pready stays 0).
REQ-020 pready=1 and pslverr=0 with pwrite=1 SHALL write, for each pstrb bit k set, byte k of the addressed register; other bytes are unchanged; wr_pulse_o[idx]=1 in the same cycle.
REQ-021 pready=1 with pwrite=0 SHALL drive prdata with the register value (RW) or the hw_status_i slice (RO) and set rd_pulse_o[idx]=1; prdata SHALL be 0 whenever pready=0 or pslverr=1.
REQ-022 pslverr SHALL be 1 only while pready=1, and only when index>=NUM_REGS, paddr[OFS-1:0]!=0, or a write targets an RO register.
REQ-023 An errored transfer SHALL change no register and raise no pulse.
REQ-024 A write with pstrb=0 SHALL complete without error, change no data, and still raise wr_pulse_o.
REQ-025 Back-to-back transfers SHALL be supported: a setup phase in the cycle after pready returns to ACCESS.
REQ-026 regs_o slices of RO registers SHALL be 0.

Reset
REQ-027 While preset=1 at a clock edge: FSM=IDLE, counter=0, all RW registers=0, pready=0, pslverr=0, prdata=0, all pulses=0.
REQ-028 Reset asserted mid-access SHALL abort the transfer with no commit; the next transfer starts from a fresh setup phase.

Structure
REQ-029 A shared package apb_regbank_pkg SHALL hold the FSM state enum, the max WAIT_STATES constant and the error-cause encoding.
REQ-030 The FSM and wait counter SHALL live in one sub-module, apb_access_fsm; register storage, decode and the read mux SHALL stay in the top.

Verification
REQ-031 Defaults; write 0xA5A5_1234 to paddr 0x004 with pstrb=0xF, then read 0x004 -> pready high in the first penable cycle, prdata=0xA5A5_1234, wr_pulse_o[1] and rd_pulse_o[1] one cycle each.
REQ-032 WAIT_STATES=3; read of 0x000 -> pready low for 3 penable cycles, high on the 4th with prdata valid only then.
REQ-033 Register 2 holds 0xFFFF_FFFF; write 0x0000_0000 with pstrb=0x5 -> register 2 = 0xFF00_FF00.
REQ-034 Access paddr 0x028 (index 10), then 0x006 (misaligned) -> pslverr=1 with pready, prdata=0, no pulses, regs_o unchanged.
REQ-035 RO_MASK bit 4 set, hw_status_i slice 4=0x0000_0060; write then read 0x010 -> write gives pslverr=1; read gives prdata=0x60, pslverr=0.
REQ-036 WAIT_STATES=5; preset=1 on the 2nd wait cycle -> no commit, pready=0, all outputs 0; the next full transfer completes normally.
